// File: rtl/vqueue_sync.sv
// vqueue_sync: single-clock circular queue with level, almost flags and registered/FWFT read; sticky error flags under VQUEUE_ERR_FLAGS_EN.
module vqueue_sync #(
  parameter int data_width   = 32,
  parameter int addr_width   = 5,
  parameter int almost_empty = 8,
  parameter int almost_full  = 8,
  parameter int fwft         = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WrEn,
  input  logic                  RdEn,
  input  logic [data_width-1:0] Data,
  output logic [data_width-1:0] Q,
  output logic                  Empty,
  output logic                  Full,
  output logic                  AlmostEmpty,
  output logic                  AlmostFull,
  output logic [addr_width:0]   Level,
  input  logic                  ErrClear,
  output logic                  Overflow,
  output logic                  Underflow
);
  localparam int depth = 1 << addr_width;
  logic [data_width-1:0] r_mem [depth];
  logic [addr_width-1:0] r_wraddr, r_rdaddr;
  logic [addr_width:0]   r_level;
  logic                  w_wr_ok, w_rd_ok;
  assign w_wr_ok     = WrEn & ~Full;
  assign w_rd_ok     = RdEn & ~Empty;
  assign Level       = r_level;
  assign Empty       = r_level == '0;
  assign Full        = r_level == (addr_width+1)'(depth);
  assign AlmostEmpty = int'(r_level) < almost_empty;
  assign AlmostFull  = depth - int'(r_level) < almost_full;
  always_ff @(posedge Clock)
    if (!Reset && w_wr_ok) r_mem[r_wraddr] <= Data;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wraddr <= '0;
      r_rdaddr <= '0;
      r_level  <= '0;
    end else begin
      r_wraddr <= r_wraddr + addr_width'(w_wr_ok);
      r_rdaddr <= r_rdaddr + addr_width'(w_rd_ok);
      r_level  <= (w_wr_ok & ~w_rd_ok) ? r_level + 1'b1 :
                  (~w_wr_ok & w_rd_ok) ? r_level - 1'b1 : r_level;
    end
  end
  generate
    if (fwft != 0) begin : g_fwft
      assign Q = r_mem[r_rdaddr];
    end else begin : g_reg
      logic [data_width-1:0] r_q;
      always_ff @(posedge Clock) begin
        if (Reset) r_q <= '0;
        else if (w_rd_ok) r_q <= r_mem[r_rdaddr];
      end
      assign Q = r_q;
    end
  endgenerate
`ifdef VQUEUE_ERR_FLAGS_EN
  logic r_ovf, r_unf;
  // a fresh error in the same cycle as ErrClear keeps the flag set
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (WrEn & Full) | (r_ovf & ~ErrClear);
      r_unf <= (RdEn & Empty) | (r_unf & ~ErrClear);
    end
  end
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;
`else
  logic w_unused;
  assign w_unused  = ErrClear;
  assign Overflow  = 1'b0;
  assign Underflow = 1'b0;
`endif
endmodule

// File: tb/tb_vqueue_sync.sv
// tb_vqueue_sync: registered and FWFT instances driven in lockstep, checked against a queue-based model.
module tb_vqueue_sync;
  localparam int DEPTH = 32;
`ifdef VQUEUE_ERR_FLAGS_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  typedef logic [84:0] vec_t;
  logic clk = 1'b0;
  logic Reset = 1'b0, WrEn = 1'b0, RdEn = 1'b0, ErrClear = 1'b0;
  logic [31:0] Data = '0;
  logic [31:0] q0, q1;
  logic e0, f0, ae0, af0, ov0, un0, e1, f1, ae1, af1, ov1, un1;
  logic [5:0] l0, l1;
  int tests = 0, failed = 0;
  logic [31:0] mq[$];
  logic [31:0] eq = '0;
  bit eovf = 1'b0, eunf = 1'b0;

  always #5 clk = ~clk;

  vqueue_sync #(.fwft(0)) dut0 (
    .Clock(clk), .Reset(Reset), .WrEn(WrEn), .RdEn(RdEn), .Data(Data), .Q(q0),
    .Empty(e0), .Full(f0), .AlmostEmpty(ae0), .AlmostFull(af0), .Level(l0),
    .ErrClear(ErrClear), .Overflow(ov0), .Underflow(un0));
  vqueue_sync #(.fwft(1)) dut1 (
    .Clock(clk), .Reset(Reset), .WrEn(WrEn), .RdEn(RdEn), .Data(Data), .Q(q1),
    .Empty(e1), .Full(f1), .AlmostEmpty(ae1), .AlmostFull(af1), .Level(l1),
    .ErrClear(ErrClear), .Overflow(ov1), .Underflow(un1));

  function automatic vec_t obs();
    return {l0, e0, f0, ae0, af0, ov0, un0, q0, l1, f1, ov1, un1, e1 ? 32'h0 : q1};
  endfunction

  function automatic vec_t expv();
    int n = mq.size();
    return {6'(n), n == 0, n == DEPTH, n < 8, DEPTH - n < 8, eovf, eunf, eq,
            6'(n), n == DEPTH, eovf, eunf, n > 0 ? mq[0] : 32'h0};
  endfunction

  task automatic cycle(input bit wr, input bit rd, input logic [31:0] d, input bit rst = 1'b0, input bit clr = 1'b0);
    bit full, empty;
    WrEn = wr; RdEn = rd; Data = d; Reset = rst; ErrClear = clr;
    @(posedge clk);
    full = mq.size() == DEPTH;
    empty = mq.size() == 0;
    if (rst) begin
      mq.delete();
      eq = '0;
      eovf = 1'b0;
      eunf = 1'b0;
    end else begin
      eovf = ERR && ((wr && full) || (eovf && !clr));
      eunf = ERR && ((rd && empty) || (eunf && !clr));
      if (rd && !empty) eq = mq.pop_front();
      if (wr && !full) mq.push_back(d);
    end
    #1;
    WrEn = 0; RdEn = 0; Reset = 0; ErrClear = 0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 32'hDEADBEEF, 1);
    tests++;
    if (obs() !== expv()) begin failed++; $display("FAIL reset got %h exp %h", obs(), expv()); end
  endtask

  task automatic test_fill_drain();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 0, 32'h11111111 + i * 32'h01010101);
      tests++;
      if (obs() !== expv()) begin failed++; $display("FAIL fill[%0d] got %h exp %h", i, obs(), expv()); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 1, 0);
      tests++;
      if (obs() !== expv()) begin failed++; $display("FAIL drain[%0d] got %h exp %h", i, obs(), expv()); end
    end
  endtask

  task automatic test_full_rw();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, $urandom);
    cycle(1, 1, 32'h55AA55AA);
    tests++;
    if (obs() !== expv() || l0 !== 6'd31 || f0 !== 1'b0) begin
      failed++; $display("FAIL full_rw got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_steady();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(1, 0, i);
    for (int i = 10; i < 50; i++) begin
      cycle(1, 1, i);
      tests++;
      if (obs() !== expv() || q0 !== 32'(i - 10)) begin
        failed++; $display("FAIL steady[%0d] got %h exp %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_fwft();
    cycle(0, 0, 0, 1);
    cycle(1, 1, 32'hCAFEF00D);
    tests++;
    if (q1 !== 32'hCAFEF00D || e1 !== 1'b0 || obs() !== expv()) begin
      failed++; $display("FAIL fwft_push got q=%h e=%b exp q=cafef00d e=0", q1, e1);
    end
    cycle(0, 1, 0);
    tests++;
    if (e1 !== 1'b1 || l1 !== 6'd0 || q0 !== 32'hCAFEF00D || obs() !== expv()) begin
      failed++; $display("FAIL fwft_pop got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cycle(1, 0, $urandom);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    cycle(1, 0, 32'h12345678, 1);
    tests++;
    if (obs() !== expv() || l0 !== 6'd0 || q0 !== 32'h0) begin
      failed++; $display("FAIL reset_mid got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_errors();
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (obs() !== expv()) begin failed++; $display("FAIL underflow[%0d] got %h exp %h", i, obs(), expv()); end
      cycle(0, 0, 0);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, i);
    cycle(1, 0, 32'hFFFFFFFF);
    tests++;
    if (obs() !== expv()) begin failed++; $display("FAIL overflow got %h exp %h", obs(), expv()); end
    cycle(0, 0, 0, 0, 1);
    tests++;
    if (obs() !== expv() || ov0 !== 1'b0 || un0 !== 1'b0) begin
      failed++; $display("FAIL errclear got %h exp %h", obs(), expv());
    end
    cycle(1, 0, 0, 0, 1);
    tests++;
    if (obs() !== expv()) begin failed++; $display("FAIL clear_vs_err got %h exp %h", obs(), expv()); end
  endtask

  task automatic test_random();
    int pw;
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      pw = (i / 250) % 2 ? 30 : 70;
      cycle($urandom_range(99) < pw, $urandom_range(99) < 100 - pw + 10, $urandom,
            $urandom_range(199) == 0, $urandom_range(19) == 0);
      tests++;
      if (obs() !== expv()) begin failed++; $display("FAIL random[%0d] got %h exp %h", i, obs(), expv()); end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_steady();
    test_fwft();
    test_reset_mid();
    test_errors();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
